// File: rtl/cpu_reg_package.sv
// Shared bus widths and register-window offsets for the module-side responder.
package cpu_reg_package;
  localparam int address_width = 16;
  localparam int data_width    = 32;

  localparam logic [2:0] RESP_CTRL_OFS     = 3'd0;
  localparam logic [2:0] RESP_STATUS_OFS   = 3'd1;
  localparam logic [2:0] RESP_EVENT_OFS    = 3'd2;
  localparam logic [2:0] RESP_IRQ_MASK_OFS = 3'd3;
  localparam logic [2:0] RESP_COUNT_LO_OFS = 3'd4;
  localparam logic [2:0] RESP_COUNT_HI_OFS = 3'd5;
  localparam logic [2:0] RESP_SCRATCH_OFS  = 3'd6;
  localparam logic [2:0] RESP_ID_OFS       = 3'd7;
  localparam int         RESP_WINDOW_WORDS = 8;
endpackage

// File: rtl/cdc_reg_responder_if.sv
// Pulsed single-cycle bus between the crossing (master) and a responder (slave).
interface cdc_reg_responder_if;
  import cpu_reg_package::*;
  logic                     we_i;
  logic [address_width-1:0] address_i;
  logic [data_width-1:0]    data_i;
  logic [data_width-1:0]    data_o;

  modport master (output we_i, output address_i, output data_i, input data_o);
  modport slave  (input we_i, input address_i, input data_i, output data_o);
endinterface

// File: rtl/resp_event_capture.sv
// Rising-edge event capture with write-1-to-clear (set wins) and registered masked IRQ.
module resp_event_capture #(
  parameter int NUM_EVENTS = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NUM_EVENTS-1:0] i_event,
  input  logic                  i_clr_we,
  input  logic [NUM_EVENTS-1:0] i_clr_data,
  input  logic [NUM_EVENTS-1:0] i_mask,
  output logic [NUM_EVENTS-1:0] o_event,
  output logic                  o_irq
);
  logic [NUM_EVENTS-1:0] r_prev;
  logic [NUM_EVENTS-1:0] r_event;
  logic                  r_irq;
  logic [NUM_EVENTS-1:0] w_set;
  logic [NUM_EVENTS-1:0] w_clr;

  always_comb begin
    w_set = i_event & ~r_prev;
    if (i_clr_we) begin
      w_clr = i_clr_data;
    end else begin
      w_clr = '0;
    end
  end

  // Set is OR-ed after the clear so a same-cycle edge survives the W1C.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_prev  <= '0;
      r_event <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_prev  <= i_event;
      r_event <= (r_event & ~w_clr) | w_set;
      r_irq   <= |(r_event & i_mask);
    end
  end

  assign o_event = r_event;
  assign o_irq   = r_irq;
endmodule

// File: rtl/cdc_reg_responder.sv
// Destination-domain register responder decoding the crossing's pulsed bus.
// Optional free-running 2-word counter enabled by CDC_RESP_COUNTER_EN.
module cdc_reg_responder
  import cpu_reg_package::*;
#(
  parameter logic [address_width-1:0] BASE_ADDRESS = 16'h9000,
  parameter logic [data_width-1:0]    CTRL_RESET   = '0,
  parameter logic [31:0]              ID_VALUE     = 32'hC0DE_0001,
  parameter int                       NUM_EVENTS   = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  cdc_reg_responder_if.slave    bus,
  output logic [data_width-1:0] ctrl_o,
  input  logic [data_width-1:0] status_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  output logic                  irq_o
);
  localparam logic [data_width-1:0] LP_ID = data_width'(ID_VALUE);

  // The idle bus is all-zero, so a zero base would decode idle as a CTRL read.
  if (BASE_ADDRESS == '0) begin : g_bad_base
    $error("cdc_reg_responder: BASE_ADDRESS must be nonzero");
  end
  if (NUM_EVENTS < 1 || NUM_EVENTS > data_width) begin : g_bad_events
    $error("cdc_reg_responder: NUM_EVENTS out of range");
  end

  logic [address_width-1:0] w_ofs_full;
  logic [2:0]               w_ofs;
  logic                     w_hit;
  logic                     w_wr;
  logic                     w_rd;
  logic [data_width-1:0]    w_rdata;
  logic [data_width-1:0]    w_count_lo;
  logic [data_width-1:0]    w_count_hi;
  logic [NUM_EVENTS-1:0]    w_event;

  logic [data_width-1:0]    r_data_o;
  logic [data_width-1:0]    r_ctrl;
  logic [data_width-1:0]    r_status;
  logic [data_width-1:0]    r_mask;
  logic [data_width-1:0]    r_scratch;

  // Unsigned wrap makes addresses below the base fall outside the window too.
  assign w_ofs_full = bus.address_i - BASE_ADDRESS;
  assign w_hit      = (w_ofs_full < address_width'(RESP_WINDOW_WORDS));
  assign w_ofs      = w_ofs_full[2:0];
  assign w_wr       = w_hit & bus.we_i;
  assign w_rd       = w_hit & ~bus.we_i;

`ifdef CDC_RESP_COUNTER_EN
  logic [2*data_width-1:0] r_count;
  logic [data_width-1:0]   r_shadow;

  // LO read latches the matching high word so a later HI read is coherent.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_count  <= '0;
      r_shadow <= '0;
    end else if (w_wr && w_ofs == RESP_COUNT_LO_OFS) begin
      r_count  <= '0;
      r_shadow <= '0;
    end else begin
      r_count <= r_count + (2*data_width)'(1);
      if (w_rd && w_ofs == RESP_COUNT_LO_OFS) begin
        r_shadow <= r_count[2*data_width-1:data_width];
      end else begin
        r_shadow <= r_shadow;
      end
    end
  end

  assign w_count_lo = r_count[data_width-1:0];
  assign w_count_hi = r_shadow;
`else
  assign w_count_lo = '0;
  assign w_count_hi = '0;
`endif

  resp_event_capture #(.NUM_EVENTS(NUM_EVENTS)) u_events (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .i_event    (event_i),
    .i_clr_we   (w_wr && (w_ofs == RESP_EVENT_OFS)),
    .i_clr_data (bus.data_i[NUM_EVENTS-1:0]),
    .i_mask     (r_mask[NUM_EVENTS-1:0]),
    .o_event    (w_event),
    .o_irq      (irq_o)
  );

  always_comb begin
    w_rdata = '0;
    case (w_ofs)
      RESP_CTRL_OFS:     w_rdata = r_ctrl;
      RESP_STATUS_OFS:   w_rdata = r_status;
      RESP_EVENT_OFS:    w_rdata = data_width'(w_event);
      RESP_IRQ_MASK_OFS: w_rdata = r_mask;
      RESP_COUNT_LO_OFS: w_rdata = w_count_lo;
      RESP_COUNT_HI_OFS: w_rdata = w_count_hi;
      RESP_SCRATCH_OFS:  w_rdata = r_scratch;
      RESP_ID_OFS:       w_rdata = LP_ID;
      default:           w_rdata = '0;
    endcase
  end

  // Return data is valid for exactly the cycle after a read strobe, else zero.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_data_o  <= '0;
      r_ctrl    <= CTRL_RESET;
      r_status  <= '0;
      r_mask    <= '0;
      r_scratch <= '0;
    end else begin
      r_data_o <= w_rd ? w_rdata : '0;
      r_status <= status_i;
      if (w_wr) begin
        case (w_ofs)
          RESP_CTRL_OFS:     r_ctrl    <= bus.data_i;
          RESP_IRQ_MASK_OFS: r_mask    <= bus.data_i;
          RESP_SCRATCH_OFS:  r_scratch <= bus.data_i;
          default:           r_ctrl    <= r_ctrl;
        endcase
      end else begin
        r_ctrl <= r_ctrl;
      end
    end
  end

  assign bus.data_o = r_data_o;
  assign ctrl_o     = r_ctrl;
endmodule

// File: tb/tb_cdc_reg_responder.sv
// Directed self-checking bench for cdc_reg_responder (data_width=32, base 0x9000).
module tb_cdc_reg_responder;
  import cpu_reg_package::*;

  logic                  clk_i;
  logic                  reset_i;
  logic [data_width-1:0] ctrl_o;
  logic [data_width-1:0] status_i;
  logic [3:0]            event_i;
  logic                  irq_o;
  int                    n_total;
  int                    n_bad;

  cdc_reg_responder_if bus_if ();

  cdc_reg_responder #(
    .BASE_ADDRESS (16'h9000),
    .CTRL_RESET   (32'h0000_0000),
    .ID_VALUE     (32'hC0DE_0001),
    .NUM_EVENTS   (4)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .bus      (bus_if.slave),
    .ctrl_o   (ctrl_o),
    .status_i (status_i),
    .event_i  (event_i),
    .irq_o    (irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one strobe for one clock, then return #1 after the edge.
  task automatic cyc(input logic we, input logic [15:0] addr, input logic [31:0] data);
    bus_if.we_i      = we;
    bus_if.address_i = addr;
    bus_if.data_i    = data;
    @(posedge clk_i);
    #1;
    bus_if.we_i      = 1'b0;
    bus_if.address_i = 16'h0000;
    bus_if.data_i    = 32'h0000_0000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 32'h0000_0000);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset_i = 1'b1;
    status_i = 32'h0000_0000;
    event_i  = 4'h0;
    bus_if.we_i      = 1'b0;
    bus_if.address_i = 16'h0000;
    bus_if.data_i    = 32'h0000_0000;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    chk("rst_data", bus_if.data_o, 32'h0000_0000);
    chk("rst_ctrl", ctrl_o, 32'h0000_0000);
    chk("rst_irq", {31'd0, irq_o}, 32'h0000_0000);

    // Basic reads, one-cycle latency, zero between strobes
    cyc(1'b0, 16'h9000, 32'h0);
    chk("rd_ctrl", bus_if.data_o, 32'h0000_0000);
    cyc(1'b0, 16'h9007, 32'h0);
    chk("rd_id", bus_if.data_o, 32'hC0DE_0001);
    idle(1);
    chk("rd_gap", bus_if.data_o, 32'h0000_0000);

    // Scratch write then immediate read; ID is read-only; CTRL write
    cyc(1'b1, 16'h9006, 32'hA5A5_5A5A);
    chk("wr_nodata", bus_if.data_o, 32'h0000_0000);
    cyc(1'b0, 16'h9006, 32'h0);
    chk("rd_scratch", bus_if.data_o, 32'hA5A5_5A5A);
    cyc(1'b1, 16'h9007, 32'h1234_5678);
    cyc(1'b0, 16'h9007, 32'h0);
    chk("id_ro", bus_if.data_o, 32'hC0DE_0001);
    cyc(1'b1, 16'h9000, 32'h0000_00FF);
    chk("ctrl_o", ctrl_o, 32'h0000_00FF);

    // Event capture, mask, IRQ timing
    event_i = 4'h4;
    cyc(1'b1, 16'h9003, 32'h0000_0004);
    chk("irq_lag", {31'd0, irq_o}, 32'h0000_0000);
    cyc(1'b0, 16'h9002, 32'h0);
    chk("evt_set", bus_if.data_o, 32'h0000_0004);
    chk("irq_on", {31'd0, irq_o}, 32'h0000_0001);
    event_i = 4'h0;
    idle(1);
    event_i = 4'h4;
    cyc(1'b1, 16'h9002, 32'h0000_0004);
    cyc(1'b0, 16'h9002, 32'h0);
    chk("set_wins", bus_if.data_o, 32'h0000_0004);
    cyc(1'b1, 16'h9002, 32'h0000_0004);
    cyc(1'b0, 16'h9002, 32'h0);
    chk("evt_clr", bus_if.data_o, 32'h0000_0000);
    chk("irq_off", {31'd0, irq_o}, 32'h0000_0000);
    event_i = 4'h0;

`ifdef CDC_RESP_COUNTER_EN
    force dut.r_count = 64'h0000_0001_FFFF_FFFF;
    cyc(1'b0, 16'h9004, 32'h0);
    release dut.r_count;
    chk("cnt_lo", bus_if.data_o, 32'hFFFF_FFFF);
    idle(3);
    cyc(1'b0, 16'h9005, 32'h0);
    chk("cnt_hi", bus_if.data_o, 32'h0000_0001);
    cyc(1'b1, 16'h9004, 32'h0);
    cyc(1'b0, 16'h9004, 32'h0);
    chk("cnt_clr", bus_if.data_o, 32'h0000_0000);
`else
    cyc(1'b0, 16'h9004, 32'h0);
    chk("cnt_lo", bus_if.data_o, 32'h0000_0000);
    idle(3);
    cyc(1'b0, 16'h9005, 32'h0);
    chk("cnt_hi", bus_if.data_o, 32'h0000_0000);
`endif

    // Back-to-back reads and out-of-window strobes
    status_i = 32'h5A5A_0F0F;
    idle(2);
    cyc(1'b0, 16'h9001, 32'h0);
    chk("b2b_status", bus_if.data_o, 32'h5A5A_0F0F);
    cyc(1'b0, 16'h9007, 32'h0);
    chk("b2b_id", bus_if.data_o, 32'hC0DE_0001);
    cyc(1'b0, 16'h8FFF, 32'h0);
    chk("below_win", bus_if.data_o, 32'h0000_0000);
    cyc(1'b0, 16'h9008, 32'h0);
    chk("above_win", bus_if.data_o, 32'h0000_0000);

    // Asynchronous reset while read data is pending
    cyc(1'b0, 16'h9006, 32'h0);
    chk("pre_rst", bus_if.data_o, 32'hA5A5_5A5A);
    #1;
    reset_i = 1'b1;
    #1;
    chk("async_rst", bus_if.data_o, 32'h0000_0000);
    chk("rst_ctrl2", ctrl_o, 32'h0000_0000);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    cyc(1'b0, 16'h9006, 32'h0);
    chk("rst_scratch", bus_if.data_o, 32'h0000_0000);
    cyc(1'b0, 16'h9003, 32'h0);
    chk("rst_mask", bus_if.data_o, 32'h0000_0000);
    cyc(1'b0, 16'h9002, 32'h0);
    chk("rst_event", bus_if.data_o, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/cdc_reg_responder.md
# cdc_reg_responder

Module-side register responder for the bus crossing. It sits in the destination clock domain and decodes the pulsed single-cycle bus transactions that the CPU-to-module crossing emits (we/address/data, all zero when idle). It provides a small register bank (control, status, W1C events with interrupt, a 2-word coherent cycle counter, scratch, ID) and returns read data exactly one cycle after each read strobe, which is when the crossing captures it.

## Interface
- BASE_ADDRESS, 16'h9000: first address of the 8-word window; must be nonzero
- CTRL_RESET, '0: reset value of CTRL
- ID_VALUE, 32'hC0DE_0001: value of ID, truncated to data_width
- NUM_EVENTS, 4: event inputs; 1..data_width
- clk_i  input  1  destination-domain clock
- reset_i  input  1  reset, asynchronous, active-high
- we_i  input  1  write strobe from crossing; zero when idle
- address_i  input  address_width  transaction address; zero when idle
- data_i  input  data_width  write data
- data_o  output  data_width  read data to crossing; valid the cycle after a read strobe, '0 otherwise
- ctrl_o  output  data_width  CTRL register contents
- status_i  input  data_width  status word, same clock domain
- event_i  input  NUM_EVENTS  level event sources, same clock domain
- irq_o  output  1  registered OR of (EVENT & IRQ_MASK)

## Operation
- Transaction strobe: address_i in [BASE_ADDRESS, BASE_ADDRESS+7]. Since the idle bus is all-zero, BASE_ADDRESS != 0 is mandatory (elaboration error otherwise). Write if we_i=1, read if we_i=0.
- Offset map: 0 CTRL RW; 1 STATUS RO (status_i registered once); 2 EVENT W1C; 3 IRQ_MASK RW; 4 COUNT_LO RO; 5 COUNT_HI RO; 6 SCRATCH RW; 7 ID RO.
- Writes to RO offsets have no effect, except that a write of any value to COUNT_LO clears the counter and the shadow.
- EVENT: event_i is registered into prev. Bit k sets on cur[k] & ~prev[k]. Writing 1 clears the bit. If a set and a clear hit the same bit in the same cycle, set wins. Bits at NUM_EVENTS and above read 0.
- Counter: 2*data_width bits, free-running, +1 every cycle, wraps to 0. A COUNT_LO read returns the low word and loads the high word of the same sampled value into the shadow. A COUNT_HI read returns the shadow. This makes LO-then-HI reads coherent across a low-word carry.
- Outside the window, data_o stays '0, so several responders can be OR-combined onto one crossing return path.
- Strobes may arrive on consecutive cycles. Each one is serviced independently with no stall.

## Timing
- Reset: data_o='0, ctrl_o=CTRL_RESET, irq_o=0. EVENT, IRQ_MASK, SCRATCH, counter, shadow and prev are all 0.
- Read latency is exactly 1 cycle: strobe in cycle N gives data_o valid in N+1 only, then '0 in N+2 unless another read arrived in N+1.
- Writes take effect at the strobe edge, so a read in N+1 returns the value written in N.
- Event edge seen in cycle N sets EVENT at N+1. irq_o follows EVENT&MASK one cycle later (N+2).
- A COUNT_LO read in cycle N samples the counter value before that edge's increment.
- Reset asserted mid-transaction: any pending data_o is dropped to '0 immediately (asynchronous).

## Configuration
- CDC_RESP_COUNTER_EN defined: counter and shadow exist as described.
- CDC_RESP_COUNTER_EN not defined: no counter or shadow is built, offsets 4 and 5 read '0, and writes to them are ignored.

## Structure
- cpu_reg_package supplies address_width and data_width. It also gains the localparams RESP_CTRL_OFS..RESP_ID_OFS (0..7) and RESP_WINDOW_WORDS=8.
- Sub-module resp_event_capture holds per-bit edge detection, W1C, set-wins priority, mask and the registered irq_o. Everything else is inline.

## Test plan
Bench configuration: data_width=32, BASE_ADDRESS=16'h9000.
- Reset, then read 0x9000 and 0x9007 → data_o=CTRL_RESET, then 32'hC0DE_0001, each one cycle after its strobe, and '0 between strobes.
- Write 0x9006=32'hA5A5_5A5A, then a read of 0x9006 on the very next cycle → 32'hA5A5_5A5A. A write to 0x9007 leaves ID unchanged.
- Pulse event_i[2], write 0x9003=4, check irq_o=1. Write 0x9002=4 in the same cycle as a new event_i[2] edge → bit stays 1. A clean clear then gives EVENT=0 and irq_o=0.
- Force counter to 32'hFFFF_FFFF low word / 0x0000_0001 high word. Read 0x9004, wait 3 cycles, read 0x9005 → 32'hFFFF_FFFF then 1, not 2. Without the macro → 0, 0.
- Back-to-back read strobes 0x9001 and 0x9007 on consecutive cycles, plus a strobe to 0x8FFF → two consecutive valid data_o words, and '0 for the out-of-window address.
- Assert reset_i the cycle after a read strobe → data_o='0 immediately and all registers at their reset values.
